// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per SHIFT/TRIAL pair, with a start/done handshake
// that matches the shift/add multiplier next to it.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TRIAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic             zdiv_q, zdiv_d;

   logic [WIDTH+1:0] diff;
   logic [WIDTH:0]   a_trial;
   logic [WIDTH-1:0] q_trial;

   // Trial subtract at WIDTH+2 bits so the sign bit cleanly says "doesn't fit".
   assign diff    = {1'b0, a_q} - {2'b00, m_q};
   assign a_trial = diff[WIDTH+1] ? a_q : diff[WIDTH:0];
   assign q_trial = {q_q[WIDTH-1:1], ~diff[WIDTH+1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      zdiv_d  = zdiv_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = '0;
               q_d    = dividend;
               m_d    = divisor;
               cnt_d  = CW'(WIDTH);
               busy_d = 1'b1;
               // A zero divisor takes one TRIAL slot so done lands one edge after acceptance.
               if (divisor == '0) begin
                  zdiv_d  = 1'b1;
                  state_d = TRIAL;
               end else begin
                  zdiv_d  = 1'b0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
            state_d    = TRIAL;
         end
         TRIAL: begin
            if (zdiv_q) begin
               quot_d  = '1;
               rem_d   = q_q;
               dz_d    = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               a_d   = a_trial;
               q_d   = q_trial;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  quot_d  = q_trial;
                  rem_d   = a_trial[WIDTH-1:0];
                  dz_d    = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            zdiv_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         zdiv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         zdiv_q  <= zdiv_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed scenarios plus a shuffled sweep of all pairs.
module tb_seq_restoring_divider;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient, remainder;
   logic         busy, done, div_by_zero;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_done = 1'b0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int a, input int b);
      exp_t e;
      if (b == 0) begin
         e.q = W'((1 << W) - 1);
         e.r = W'(a);
         e.dz = 1'b1;
      end else begin
         e.q = W'(a / b);
         e.r = W'(a % b);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (done) begin
         chk("done_width", int'(prev_done), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.dz));
         end
      end
      prev_done <= done;
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // Issue one division, verify done latency and busy length; optional ignored start pulses.
   task automatic do_div(input int a, input int b, input bit pulse);
      int n;
      int nb;
      int lat;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
      @(negedge clock);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      exp_q.push_back(model(a, b));
      @(posedge clock);
      #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = (b == 0) ? 1 : 2 * W;
      nb = busy ? 1 : 0;
      n = 0;
      while (!done && n < 40) begin
         if (pulse && (n + 1 == 3 || n + 1 == 8)) begin
            start = 1'b1; dividend = 4'd2; divisor = 4'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock);
         #1;
         n++;
         if (busy) nb++;
      end
      start = 1'b0;
      if (!done) chk("done_timeout", 1, 0);
      chk("done_latency", n, lat);
      chk("busy_cycles", nb, lat + 1);
      @(posedge clock);
      #1;
      chk("busy_after_done", int'(busy), 0);
      chk("done_after_done", int'(done), 0);
   endtask

   initial begin
      int pairs[256];
      int n;
      do_reset();
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dz", int'(div_by_zero), 0);

      do_div(13, 4, 1'b0);

      do_reset();
      do_div(15, 1, 1'b0);
      do_div(7, 9, 1'b0);
      do_div(0, 5, 1'b0);

      do_reset();
      do_div(11, 0, 1'b0);
      do_div(6, 3, 1'b0);

      do_reset();
      do_div(13, 4, 1'b1);

      // Mid-operation reset: the partial result is dropped and no done follows.
      do_reset();
      @(negedge clock);
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_quotient", int'(quotient), 0);
      chk("midrst_remainder", int'(remainder), 0);
      chk("midrst_dz", int'(div_by_zero), 0);
      reset = 1'b0;
      n = 0;
      repeat (12) begin
         @(posedge clock);
         #1;
         if (done || busy) n++;
      end
      chk("midrst_quiet", n, 0);
      do_div(14, 3, 1'b0);

      // Shuffled sweep of every dividend/divisor pair.
      do_reset();
      foreach (pairs[i]) pairs[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int t;
         j = int'($urandom_range(i, 0));
         t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
      end
      foreach (pairs[i]) do_div(pairs[i] >> 4, pairs[i] & 15, 1'b0);

      repeat (3) @(posedge clock);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
